// File: rtl/change_return_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : change_return_sequencer_pkg
//  Description : Shared sizes, coin values, timer reload and FSM encodings for
//                the vending machine change-return sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package change_return_sequencer_pkg;

    localparam int kNumCoins  = 3;
    localparam int kNumItems  = 4;
    localparam int kTotalBits = 16;

    localparam int kWaitTime  = 10;
    localparam int kCoinVal0  = 100;
    localparam int kCoinVal1  = 500;
    localparam int kCoinVal2  = 1000;

    localparam logic [1:0] kStIdle   = 2'd0;
    localparam logic [1:0] kStWait   = 2'd1;
    localparam logic [1:0] kStReturn = 2'd2;
    localparam logic [1:0] kStDone   = 2'd3;

endpackage : change_return_sequencer_pkg
`default_nettype wire

// File: rtl/change_return_sequencer_coin_selector.sv
`default_nettype none
// ============================================================================
//  Module      : change_return_sequencer_coin_selector
//  Description : Combinational picker of the largest coin not exceeding the
//                remaining balance. Returns zero when no coin fits.
//  Ports       : i_rem   - remaining balance to pay out
//                o_coin  - one-hot coin index (0 when nothing fits)
//                o_value - value of the selected coin (0 when nothing fits)
//  Revision    : 1.0 - initial release
// ============================================================================
module change_return_sequencer_coin_selector
    import change_return_sequencer_pkg::*;
#(
    parameter int COIN_VAL_0 = kCoinVal0,
    parameter int COIN_VAL_1 = kCoinVal1,
    parameter int COIN_VAL_2 = kCoinVal2
) (
    input  logic [kTotalBits-1:0] i_rem,
    output logic [kNumCoins-1:0]  o_coin,
    output logic [kTotalBits-1:0] o_value
);

    localparam logic [kTotalBits-1:0] c_val_0 = kTotalBits'(COIN_VAL_0);
    localparam logic [kTotalBits-1:0] c_val_1 = kTotalBits'(COIN_VAL_1);
    localparam logic [kTotalBits-1:0] c_val_2 = kTotalBits'(COIN_VAL_2);

    always_comb begin
        o_coin  = '0;
        o_value = '0;
        if (i_rem >= c_val_2) begin
            o_coin  = 3'b100;
            o_value = c_val_2;
        end else if (i_rem >= c_val_1) begin
            o_coin  = 3'b010;
            o_value = c_val_1;
        end else if (i_rem >= c_val_0) begin
            o_coin  = 3'b001;
            o_value = c_val_0;
        end
    end

endmodule : change_return_sequencer_coin_selector
`default_nettype wire

// File: rtl/change_return_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : change_return_sequencer
//  Description : Vending transaction controller. Tracks customer inactivity,
//                decides when a transaction ends, pays the balance out one
//                coin per cycle (largest first) and then pulses a clear.
//  Ports       : clk, reset_n (async, active low)
//                i_input_coin     - one-hot coin inserted this cycle
//                i_select_item    - one-hot item request this cycle
//                i_trigger_return - customer return request
//                current_total    - live balance from the balance stage
//                o_return_changes - high in RETURN/DONE
//                o_return_coin    - one-hot coin paid out this cycle
//                o_clear_total    - one-cycle balance clear pulse
//                o_reject_coin    - echo of coins inserted during payout
//                o_residue        - sticky: last payout left a residue
//                o_busy           - controller not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module change_return_sequencer
    import change_return_sequencer_pkg::*;
#(
    parameter int WAIT_TIME  = kWaitTime,
    parameter int COIN_VAL_0 = kCoinVal0,
    parameter int COIN_VAL_1 = kCoinVal1,
    parameter int COIN_VAL_2 = kCoinVal2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [kNumCoins-1:0]  i_input_coin,
    input  logic [kNumItems-1:0]  i_select_item,
    input  logic                  i_trigger_return,
    input  logic [kTotalBits-1:0] current_total,
    output logic                  o_return_changes,
    output logic [kNumCoins-1:0]  o_return_coin,
    output logic                  o_clear_total,
    output logic [kNumCoins-1:0]  o_reject_coin,
    output logic                  o_residue,
    output logic                  o_busy
);

    localparam int                   c_timer_w   = $clog2(WAIT_TIME + 1);
    localparam logic [c_timer_w-1:0] c_wait_load = c_timer_w'(WAIT_TIME);
    localparam logic [c_timer_w-1:0] c_timer_one = c_timer_w'(1);

    logic [1:0]            r_state_q,   w_state_d;
    logic [c_timer_w-1:0]  r_timer_q,   w_timer_d;
    logic [kTotalBits-1:0] r_rem_q,     w_rem_d;
    logic                  r_residue_q, w_residue_d;
    logic [kNumCoins-1:0]  r_coin_q,    w_coin_d;
    logic [kNumCoins-1:0]  r_reject_q,  w_reject_d;
    logic                  r_clear_q,   w_clear_d;
    logic                  r_retchg_q,  w_retchg_d;
    logic                  r_busy_q,    w_busy_d;

    logic [kNumCoins-1:0]  w_sel_coin;
    logic [kTotalBits-1:0] w_sel_value;
    logic                  w_coin_in;
    logic                  w_activity;

    change_return_sequencer_coin_selector #(
        .COIN_VAL_0 (COIN_VAL_0),
        .COIN_VAL_1 (COIN_VAL_1),
        .COIN_VAL_2 (COIN_VAL_2)
    ) u_coin_selector (
        .i_rem   (r_rem_q),
        .o_coin  (w_sel_coin),
        .o_value (w_sel_value)
    );

    assign w_coin_in  = |i_input_coin;
    assign w_activity = w_coin_in | (|i_select_item);

    always_comb begin
        w_state_d   = r_state_q;
        w_timer_d   = r_timer_q;
        w_rem_d     = r_rem_q;
        w_residue_d = r_residue_q;
        w_coin_d    = '0;
        w_reject_d  = '0;
        case (r_state_q)
            kStIdle: begin
                if (w_coin_in) begin
                    w_state_d   = kStWait;
                    w_timer_d   = c_wait_load;
                    w_residue_d = 1'b0;
                end
            end
            kStWait: begin
                // Trigger wins over timeout, timeout over exact purchase,
                // exact purchase over a timer reload.
                if (i_trigger_return || (!w_activity && r_timer_q == c_timer_one)) begin
                    w_state_d = kStReturn;
                    w_rem_d   = current_total;
                    w_timer_d = '0;
                end else if (current_total == '0 && !w_coin_in) begin
                    w_state_d = kStIdle;
                    w_timer_d = '0;
                end else if (w_activity) begin
                    w_timer_d = c_wait_load;
                end else if (r_timer_q != '0) begin
                    w_timer_d = r_timer_q - c_timer_one;
                end
            end
            kStReturn: begin
                w_reject_d = i_input_coin;
                if (r_rem_q == '0) begin
                    w_state_d = kStDone;
                end else if (w_sel_coin == '0) begin
                    // Sub-coin residue cannot be paid; flag it and drop it.
                    w_state_d   = kStDone;
                    w_residue_d = 1'b1;
                    w_rem_d     = '0;
                end else begin
                    w_coin_d = w_sel_coin;
                    w_rem_d  = r_rem_q - w_sel_value;
                end
            end
            kStDone: begin
                w_reject_d = i_input_coin;
                w_state_d  = kStIdle;
            end
            default: begin
                w_state_d = kStIdle;
            end
        endcase

        // Status outputs are registered from the next state so they line up
        // with the state register itself.
        w_clear_d  = (w_state_d == kStDone);
        w_retchg_d = (w_state_d == kStReturn) || (w_state_d == kStDone);
        w_busy_d   = (w_state_d != kStIdle);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state_q   <= kStIdle;
            r_timer_q   <= '0;
            r_rem_q     <= '0;
            r_residue_q <= 1'b0;
            r_coin_q    <= '0;
            r_reject_q  <= '0;
            r_clear_q   <= 1'b0;
            r_retchg_q  <= 1'b0;
            r_busy_q    <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_timer_q   <= w_timer_d;
            r_rem_q     <= w_rem_d;
            r_residue_q <= w_residue_d;
            r_coin_q    <= w_coin_d;
            r_reject_q  <= w_reject_d;
            r_clear_q   <= w_clear_d;
            r_retchg_q  <= w_retchg_d;
            r_busy_q    <= w_busy_d;
        end
    end

    assign o_return_changes = r_retchg_q;
    assign o_return_coin    = r_coin_q;
    assign o_clear_total    = r_clear_q;
    assign o_reject_coin    = r_reject_q;
    assign o_residue        = r_residue_q;
    assign o_busy           = r_busy_q;

endmodule : change_return_sequencer
`default_nettype wire

// File: tb/tb_change_return_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_change_return_sequencer
//  Description : Directed self-checking bench for change_return_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_change_return_sequencer;
    import change_return_sequencer_pkg::*;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic [kNumCoins-1:0]  i_input_coin;
    logic [kNumItems-1:0]  i_select_item;
    logic                  i_trigger_return;
    logic [kTotalBits-1:0] current_total;
    logic                  o_return_changes;
    logic [kNumCoins-1:0]  o_return_coin;
    logic                  o_clear_total;
    logic [kNumCoins-1:0]  o_reject_coin;
    logic                  o_residue;
    logic                  o_busy;

    int total = 0;
    int bad   = 0;

    change_return_sequencer dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .i_input_coin     (i_input_coin),
        .i_select_item    (i_select_item),
        .i_trigger_return (i_trigger_return),
        .current_total    (current_total),
        .o_return_changes (o_return_changes),
        .o_return_coin    (o_return_coin),
        .o_clear_total    (o_clear_total),
        .o_reject_coin    (o_reject_coin),
        .o_residue        (o_residue),
        .o_busy           (o_busy)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Packs {ret_changes, coin[2:0], clear, reject[2:0], residue, busy}.
    function automatic logic [31:0] outs();
        return 32'({o_return_changes, o_return_coin, o_clear_total,
                    o_reject_coin, o_residue, o_busy});
    endfunction

    function automatic logic [31:0] pk(input logic rc, input logic [2:0] cn,
                                       input logic cl, input logic [2:0] rj,
                                       input logic rs, input logic bz);
        return 32'({rc, cn, cl, rj, rs, bz});
    endfunction

    initial begin
        reset_n          = 1'b0;
        i_input_coin     = '0;
        i_select_item    = '0;
        i_trigger_return = 1'b0;
        current_total    = '0;
        cyc(); cyc();
        chk("reset_outputs", outs(), pk(0, 3'b000, 0, 3'b000, 0, 0));
        reset_n = 1'b1;

        // Trigger in IDLE does nothing.
        i_trigger_return = 1'b1;
        cyc();
        chk("idle_trigger_ignored", outs(), pk(0, 3'b000, 0, 3'b000, 0, 0));
        i_trigger_return = 1'b0;

        // ---------------- payout order 1700 ----------------
        i_input_coin = 3'b100; cyc();
        chk("p1_wait", outs(), pk(0, 3'b000, 0, 3'b000, 0, 1));
        i_input_coin = 3'b010; current_total = 16'd1000; cyc();
        i_input_coin = 3'b001; current_total = 16'd1500; cyc();
        i_input_coin = 3'b001; current_total = 16'd1600; cyc();
        i_input_coin = 3'b000; current_total = 16'd1700; i_trigger_return = 1'b1; cyc();
        i_trigger_return = 1'b0;
        chk("p1_return_entry", outs(), pk(1, 3'b000, 0, 3'b000, 0, 1));
        cyc(); chk("p1_coin0", 32'(o_return_coin), 32'h4);
        cyc(); chk("p1_coin1", 32'(o_return_coin), 32'h2);
        cyc(); chk("p1_coin2", 32'(o_return_coin), 32'h1);
        cyc(); chk("p1_coin3", 32'(o_return_coin), 32'h1);
        cyc(); chk("p1_done", outs(), pk(1, 3'b000, 1, 3'b000, 0, 1));
        current_total = '0;
        cyc(); chk("p1_idle", outs(), pk(0, 3'b000, 0, 3'b000, 0, 0));

        // ---------------- timeout, no activity ----------------
        i_input_coin = 3'b010; cyc();
        i_input_coin = 3'b000; current_total = 16'd500;
        for (int i = 1; i <= 9; i++) begin
            cyc();
            chk("t1_still_wait", 32'(o_return_changes), 32'h0);
        end
        cyc(); chk("t1_return_at_10", outs(), pk(1, 3'b000, 0, 3'b000, 0, 1));
        cyc(); chk("t1_coin", 32'(o_return_coin), 32'h2);
        cyc(); chk("t1_done", outs(), pk(1, 3'b000, 1, 3'b000, 0, 1));
        current_total = '0;
        cyc(); chk("t1_idle", 32'(o_busy), 32'h0);

        // ---------------- timeout delayed by a coin at cycle 8 ----------------
        i_input_coin = 3'b010; cyc();
        i_input_coin = 3'b000; current_total = 16'd500;
        for (int i = 1; i <= 7; i++) cyc();
        i_input_coin = 3'b010; cyc();
        i_input_coin = 3'b000; current_total = 16'd1000;
        for (int i = 1; i <= 9; i++) begin
            cyc();
            chk("t2_still_wait", 32'(o_return_changes), 32'h0);
        end
        cyc(); chk("t2_return_at_18", 32'(o_return_changes), 32'h1);
        cyc(); chk("t2_coin", 32'(o_return_coin), 32'h4);
        cyc(); chk("t2_done", 32'(o_clear_total), 32'h1);
        current_total = '0;
        cyc();

        // ---------------- exact purchase ----------------
        i_input_coin = 3'b010; cyc();
        i_input_coin = 3'b000; current_total = 16'd500; i_select_item = 4'b0001; cyc();
        chk("e_wait", outs(), pk(0, 3'b000, 0, 3'b000, 0, 1));
        i_select_item = '0; current_total = '0; cyc();
        chk("e_idle", outs(), pk(0, 3'b000, 0, 3'b000, 0, 0));
        cyc();
        chk("e_no_clear", outs(), pk(0, 3'b000, 0, 3'b000, 0, 0));

        // ---------------- residue ----------------
        i_input_coin = 3'b001; cyc();
        i_input_coin = 3'b000; current_total = 16'd150; i_trigger_return = 1'b1; cyc();
        i_trigger_return = 1'b0;
        cyc(); chk("r_coin", outs(), pk(1, 3'b001, 0, 3'b000, 0, 1));
        cyc(); chk("r_done", outs(), pk(1, 3'b000, 1, 3'b000, 1, 1));
        current_total = '0;
        cyc(); chk("r_idle_sticky", outs(), pk(0, 3'b000, 0, 3'b000, 1, 0));
        cyc(); chk("r_sticky2", 32'(o_residue), 32'h1);
        i_input_coin = 3'b001; cyc();
        chk("r_cleared", outs(), pk(0, 3'b000, 0, 3'b000, 0, 1));
        i_input_coin = 3'b000; current_total = '0; cyc();
        chk("r_exit", 32'(o_busy), 32'h0);

        // ---------------- reject during payout ----------------
        i_input_coin = 3'b100; cyc();
        i_input_coin = 3'b100; current_total = 16'd1000; cyc();
        i_input_coin = 3'b000; current_total = 16'd2000; i_trigger_return = 1'b1; cyc();
        i_trigger_return = 1'b0;
        cyc(); chk("j_first", outs(), pk(1, 3'b100, 0, 3'b000, 0, 1));
        i_input_coin = 3'b001;
        cyc(); chk("j_second", outs(), pk(1, 3'b100, 0, 3'b001, 0, 1));
        i_input_coin = 3'b000;
        cyc(); chk("j_done", outs(), pk(1, 3'b000, 1, 3'b000, 0, 1));
        current_total = '0;
        cyc(); chk("j_idle", outs(), pk(0, 3'b000, 0, 3'b000, 0, 0));

        // ---------------- asynchronous reset mid-RETURN ----------------
        i_input_coin = 3'b010; cyc();
        i_input_coin = 3'b000; current_total = 16'd600; i_trigger_return = 1'b1; cyc();
        i_trigger_return = 1'b0;
        cyc(); chk("a_first_coin", 32'(o_return_coin), 32'h2);
        #2 reset_n = 1'b0;
        #1 chk("a_async_clear", outs(), pk(0, 3'b000, 0, 3'b000, 0, 0));
        cyc();
        reset_n = 1'b1; current_total = '0;
        cyc(); chk("a_after1", outs(), pk(0, 3'b000, 0, 3'b000, 0, 0));
        cyc(); chk("a_after2", outs(), pk(0, 3'b000, 0, 3'b000, 0, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time bound so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_change_return_sequencer
`default_nettype wire

// File: doc/change_return_sequencer.md
Name: change_return_sequencer

Overview:
- Transaction controller for the vending machine datapath.
- Tracks customer inactivity with a wait timer and decides when a transaction ends.
- On a return request or timeout, pays out the remaining balance one coin per cycle, largest denomination first.
- Then pulses a clear so the balance register returns to zero. It sits beside the balance/output register stage and drives its return_changes control and coin outputs.

Parameters:
- WAIT_TIME, 10, inactivity cycles in WAIT before automatic return.
- COIN_VAL_0, 100, value of coin index 0 (smallest).
- COIN_VAL_1, 500, value of coin index 1.
- COIN_VAL_2, 1000, value of coin index 2 (largest). kNumCoins is 3.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- i_input_coin  in  kNumCoins  one-hot coin inserted this cycle.
- i_select_item  in  kNumItems  one-hot item request this cycle.
- i_trigger_return  in  1  customer return request, level or pulse.
- current_total  in  kTotalBits  live balance from the balance register stage.
- o_return_changes  out  1  high while in RETURN or DONE; gates item availability in the balance stage.
- o_return_coin  out  kNumCoins  one-hot coin paid out this cycle, or 0.
- o_clear_total  out  1  one-cycle pulse; the balance stage loads 0.
- o_reject_coin  out  kNumCoins  echo of coins inserted during RETURN/DONE; these are refunded, not credited.
- o_residue  out  1  sticky: last payout left a residue not representable in coins.
- o_busy  out  1  state != IDLE.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE, timer=0, rem=0.
  - All outputs 0, including o_residue.
  - Reset mid-RETURN aborts the payout immediately. No further coins are emitted and no clear pulse is produced.
- All outputs are registered: an input event sampled at edge n is visible after edge n+1.
- States:
  - IDLE -> WAIT on any nonzero i_input_coin. Loads timer=WAIT_TIME and clears o_residue.
  - WAIT:
    - Any coin or item select reloads timer=WAIT_TIME; otherwise timer decrements by 1.
    - -> RETURN if i_trigger_return=1, or if timer==1 while decrementing (timeout).
    - -> IDLE if current_total==0 with no coin this cycle (exact purchase).
    - Priority: trigger > timeout > zero-total > reload.
  - RETURN:
    - On entry, rem <= current_total, sampled on the transition edge.
    - Each cycle, pick the largest COIN_VAL_k <= rem. Assert o_return_coin bit k and set rem <= rem - COIN_VAL_k.
    - If rem==0 -> DONE, no coin that cycle.
    - If 0 < rem < COIN_VAL_0 -> DONE with o_residue=1; the residue is discarded.
  - DONE:
    - o_clear_total=1 and o_return_changes=1 for exactly one cycle, then -> IDLE.
- Coins inserted in RETURN/DONE are mirrored on o_reject_coin the next cycle and never change rem.
- Item selects in RETURN/DONE are ignored.
- i_trigger_return in IDLE has no effect.
- A trigger held high through DONE does not restart RETURN. It re-arms only after passing through IDLE with no balance.
- Arithmetic:
  - rem is kTotalBits wide. Subtraction never underflows because the selected coin is <= rem.
  - timer is $clog2(WAIT_TIME+1) bits wide and saturates at 0.
- Payout length is bounded by rem/COIN_VAL_0 cycles; no upper time-out in RETURN.

Decomposition:
- Add coin value constants (kCoinVal0..2), state encodings (kStIdle, kStWait, kStReturn, kStDone) and kWaitTime to vending_machine_def.v alongside kNumCoins, kNumItems and kTotalBits.
- One natural sub-module: coin_selector. It is combinational: rem in, one-hot largest fitting coin plus its value out, with a zero output when nothing fits. The FSM, timer and rem register remain in the top.

Test Plan:
- Payout order: insert 1000, 500, 100, 100 (total 1700), pulse i_trigger_return -> o_return_coin = 100b, 010b, 001b, 001b on four consecutive cycles, then o_clear_total pulse, o_busy=0, o_residue=0.
- Timeout: WAIT_TIME=10, insert 500, then idle -> RETURN entered exactly 10 cycles after the coin cycle, one 010b coin, clear pulse. A coin inserted at cycle 8 delays entry to 10 cycles after that coin.
- Exact purchase: insert 500, select item with the balance stage dropping current_total to 0 -> IDLE, no coins, no clear pulse.
- Residue: force current_total=150 at trigger -> one 001b coin, then DONE with o_residue=1. o_residue stays 1 until the next coin insert in IDLE.
- Reject during payout: total 2000, trigger, insert 100 during the first payout cycle -> o_reject_coin=001b for one cycle, payout stays 100b, 100b.
- Asynchronous reset mid-RETURN: assert reset_n=0 between clock edges after the first coin -> all outputs 0 immediately, state IDLE, no clear pulse after release.
